game_score_ctrl: RTL and testbench

Game-flow controller that sequences the score datapath for the runner game. Owns the IDLE/RUN/PAUSE/OVER state machine, generates the score-tick prescale, and keeps the running score and session high score in BCD digits ready for the seven-segment decoders. Sits between the push-button and collision-detect logic and the `ssdec` display instances in the team top level. Replaces the free-running score counter/clock-divider pair, which has no start, pause or stop control.

---
 rtl/game_score_ctrl.sv | 166 ++++++++++++++++
 tb/tb_game_score_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_score_ctrl.sv
// Game-flow controller for the runner game: IDLE/RUN/PAUSE/OVER sequencing,
// score-tick prescaler, saturating BCD score, session high score and game-over blink.
module game_score_ctrl #(
  parameter int TICK_DIV  = 10,
  parameter int BLINK_DIV = 50
) (
  input  logic       clk,
  input  logic       nRst_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       collision_i,
  output logic [1:0] state_o,
  output logic [3:0] score_tens_o,
  output logic [3:0] score_units_o,
  output logic [3:0] hi_tens_o,
  output logic [3:0] hi_units_o,
  output logic       score_tick_o,
  output logic       new_high_o,
  output logic       blink_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          start_hist_q, pause_hist_q;
  logic          start_edge, pause_edge;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tens_q, tens_d, units_q, units_d;
  logic [3:0]    hi_tens_q, hi_tens_d, hi_units_q, hi_units_d;
  logic          tick_q, tick_d;
  logic          new_high_q, new_high_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          presc_tc, score_max, score_beats_hi;

  // BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [3:0] tens, input logic [3:0] units);
    if (tens == 4'd9 && units == 4'd9) return {tens, units};
    else if (units == 4'd9)            return {tens + 4'd1, 4'd0};
    else                               return {tens, units + 4'd1};
  endfunction

  assign start_edge     = start_i & ~start_hist_q;
  assign pause_edge     = pause_i & ~pause_hist_q;
  assign presc_tc       = (presc_q == PRESC_TC);
  assign score_max      = (tens_q == 4'd9) && (units_q == 4'd9);
  assign score_beats_hi = ({tens_q, units_q} > {hi_tens_q, hi_units_q});

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      state_q      <= IDLE;
      start_hist_q <= 1'b0;
      pause_hist_q <= 1'b0;
      presc_q      <= '0;
      tens_q       <= 4'd0;
      units_q      <= 4'd0;
      hi_tens_q    <= 4'd0;
      hi_units_q   <= 4'd0;
      tick_q       <= 1'b0;
      new_high_q   <= 1'b0;
      blink_q      <= 1'b0;
      bcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_hist_q <= start_i;
      pause_hist_q <= pause_i;
      presc_q      <= presc_d;
      tens_q       <= tens_d;
      units_q      <= units_d;
      hi_tens_q    <= hi_tens_d;
      hi_units_q   <= hi_units_d;
      tick_q       <= tick_d;
      new_high_q   <= new_high_d;
      blink_q      <= blink_d;
      bcnt_q       <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = RUN;
      RUN: begin
        if (collision_i)     state_d = OVER;
        else if (pause_edge) state_d = PAUSE;
      end
      PAUSE:   if (pause_edge || start_edge) state_d = RUN;
      OVER:    if (start_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Blink state defaults to cleared so it drops whenever OVER is left or entered.
  always_comb begin
    presc_d    = presc_q;
    tens_d     = tens_q;
    units_d    = units_q;
    hi_tens_d  = hi_tens_q;
    hi_units_d = hi_units_q;
    tick_d     = 1'b0;
    new_high_d = new_high_q;
    blink_d    = 1'b0;
    bcnt_d     = '0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          presc_d    = '0;
          tens_d     = 4'd0;
          units_d    = 4'd0;
          new_high_d = 1'b0;
        end
      end
      RUN: begin
        if (collision_i) begin
          if (score_beats_hi) begin
            hi_tens_d  = tens_q;
            hi_units_d = units_q;
            new_high_d = 1'b1;
          end
        end else if (!pause_edge) begin
          if (presc_tc) begin
            presc_d = '0;
            if (!score_max) begin
              {tens_d, units_d} = bcd_inc_sat(tens_q, units_q);
              tick_d            = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      OVER: begin
        if (!start_edge) begin
          if (bcnt_q == BLINK_TC) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end else begin
            bcnt_d  = bcnt_q + BW'(1);
            blink_d = blink_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign score_tens_o  = tens_q;
  assign score_units_o = units_q;
  assign hi_tens_o     = hi_tens_q;
  assign hi_units_o    = hi_units_q;
  assign score_tick_o  = tick_q;
  assign new_high_o    = new_high_q;
  assign blink_o       = blink_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Bench for game_score_ctrl: directed game scenarios with literal expectations plus
// randomized button/collision traffic, all checked every cycle against a behavioural model.
module tb_game_score_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int BLINK_DIV = 50;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       start = 1'b0, pause = 1'b0, coll = 1'b0;
  logic [1:0] state_o;
  logic [3:0] score_tens_o, score_units_o, hi_tens_o, hi_units_o;
  logic       score_tick_o, new_high_o, blink_o;

  int checks = 0;
  int failures = 0;

  game_score_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk          (clk),
    .nRst_i       (nRst),
    .start_i      (start),
    .pause_i      (pause),
    .collision_i  (coll),
    .state_o      (state_o),
    .score_tens_o (score_tens_o),
    .score_units_o(score_units_o),
    .hi_tens_o    (hi_tens_o),
    .hi_units_o   (hi_units_o),
    .score_tick_o (score_tick_o),
    .new_high_o   (new_high_o),
    .blink_o      (blink_o)
  );

  always #5 clk = ~clk;

  // Model: score as a plain integer, RUN time and OVER time as elapsed cycle counts.
  typedef struct packed {
    int st;
    int score;
    int hi;
    int rc;
    int oc;
    bit sh;
    bit ph;
    bit tick;
    bit nh;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(mdl_t cur, bit s, bit p, bit c);
    mdl_t n;
    bit se, pe;
    n = cur;
    se = s && !cur.sh;
    pe = p && !cur.ph;
    n.sh = s;
    n.ph = p;
    n.tick = 1'b0;
    case (cur.st)
      0: if (se) begin n.st = 1; n.score = 0; n.rc = 0; n.nh = 1'b0; end
      1: begin
        if (c) begin
          n.st = 3;
          n.oc = 0;
          if (cur.score > cur.hi) begin n.hi = cur.score; n.nh = 1'b1; end
        end else if (pe) begin
          n.st = 2;
        end else begin
          n.rc = cur.rc + 1;
          if ((n.rc % TICK_DIV) == 0 && cur.score < 99) begin
            n.score = cur.score + 1;
            n.tick = 1'b1;
          end
        end
      end
      2: if (pe || se) n.st = 1;
      default: if (se) n.st = 0; else n.oc = cur.oc + 1;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) m <= '0;
    else       m <= step(m, start, pause, coll);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("state", int'(state_o), m.st);
    chk("score_tens", int'(score_tens_o), m.score / 10);
    chk("score_units", int'(score_units_o), m.score % 10);
    chk("hi_tens", int'(hi_tens_o), m.hi / 10);
    chk("hi_units", int'(hi_units_o), m.hi % 10);
    chk("score_tick", int'(score_tick_o), int'(m.tick));
    chk("new_high", int'(new_high_o), int'(m.nh));
    chk("blink", int'(blink_o), (m.st == 3) ? ((m.oc / BLINK_DIV) % 2) : 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  function automatic int score_now();
    return int'(score_tens_o) * 10 + int'(score_units_o);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int ticks, first, rise, fall, sat_ticks, prev;
    bit seen_9_10;

    // Reset, then start and run 35 cycles.
    cyc(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_score", score_now(), 0);
    chk("rst_blink", int'(blink_o), 0);
    nRst = 1'b1;
    cyc(1);
    pulse_start();
    chk("t1_run", int'(state_o), 1);
    ticks = 0; first = -1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (score_tick_o) begin
        ticks++;
        if (first < 0) first = i;
      end
    end
    chk("t1_state", int'(state_o), 1);
    chk("t1_score", score_now(), 3);
    chk("t1_ticks", ticks, 3);
    chk("t1_first_tick", first, 10);

    // Pause with prescaler at 4, hold, resume; next tick 6 cycles later.
    cyc(9);
    pulse_pause();
    chk("t2_paused", int'(state_o), 2);
    chk("t2_score_at_pause", score_now(), 4);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (score_tick_o) ticks++;
    end
    chk("t2_ticks_paused", ticks, 0);
    chk("t2_score_frozen", score_now(), 4);
    pulse_pause();
    chk("t2_resumed", int'(state_o), 1);
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      @(negedge clk);
      if (score_tick_o) first = i;
    end
    chk("t2_resume_tick", first, 6);
    chk("t2_score_after", score_now(), 5);

    // Saturation at 99.
    ticks = 0; sat_ticks = 0; seen_9_10 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      prev = score_now();
      @(negedge clk);
      if (score_tick_o) ticks++;
      if (prev == 99 && score_tick_o) sat_ticks++;
      if (prev == 9 && score_now() == 10) seen_9_10 = 1'b1;
    end
    chk("t3_score", score_now(), 99);
    chk("t3_ticks", ticks, 94);
    chk("t3_sat_ticks", sat_ticks, 0);
    chk("t3_seen_9_to_10", int'(seen_9_10), 1);

    // Reset in RUN, new game, collide at terminal count with score 42.
    #2 nRst = 1'b0;
    #1 chk("t4_rst_score", score_now(), 0);
    @(negedge clk);
    nRst = 1'b1;
    cyc(1);
    pulse_start();
    cyc(429);
    chk("t4_score_pre", score_now(), 42);
    coll = 1'b1;
    @(negedge clk);
    coll = 1'b0;
    chk("t4_state", int'(state_o), 3);
    chk("t4_score", score_now(), 42);
    chk("t4_hi", int'(hi_tens_o) * 10 + int'(hi_units_o), 42);
    chk("t4_new_high", int'(new_high_o), 1);
    chk("t4_blink0", int'(blink_o), 0);
    rise = -1; fall = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (blink_o && rise < 0) rise = i;
      if (!blink_o && rise >= 0 && fall < 0) fall = i;
    end
    chk("t4_blink_rise", rise, 50);
    chk("t4_blink_fall", fall, 100);

    // Second game with a lower score.
    pulse_start();
    chk("t5_idle", int'(state_o), 0);
    chk("t5_nh_kept", int'(new_high_o), 1);
    chk("t5_blink_off", int'(blink_o), 0);
    cyc(1);
    pulse_start();
    chk("t5_run", int'(state_o), 1);
    chk("t5_score_clr", score_now(), 0);
    chk("t5_nh_clr", int'(new_high_o), 0);
    cyc(174);
    coll = 1'b1;
    @(negedge clk);
    coll = 1'b0;
    chk("t5_over", int'(state_o), 3);
    chk("t5_score", score_now(), 17);
    chk("t5_hi", int'(hi_tens_o) * 10 + int'(hi_units_o), 42);
    chk("t5_new_high", int'(new_high_o), 0);

    // Asynchronous reset in OVER with start held through release.
    #2 nRst = 1'b0;
    #1;
    chk("t6_state", int'(state_o), 0);
    chk("t6_score", score_now(), 0);
    chk("t6_hi", int'(hi_tens_o) * 10 + int'(hi_units_o), 0);
    chk("t6_new_high", int'(new_high_o), 0);
    start = 1'b1;
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("t6_run_after_rst", int'(state_o), 1);
    start = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 19) == 0);
      pause = ($urandom_range(0, 24) == 0);
      coll  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #3 nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
      end
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
